// File: rtl/gpu_mem_pkg.sv
// gpu_mem_pkg: shared state/op types and counter width for the memory responder
package gpu_mem_pkg;
    typedef enum logic [1:0] {MR_IDLE, MR_BUSY, MR_RESP} mr_state_t;
    typedef enum logic {MR_READ, MR_WRITE} mr_op_t;
    localparam int LAT_CNT_BITS = 4;
endpackage

// File: rtl/mem_responder_channel.sv
// mem_responder_channel: one request/ready handshake FSM with latency counter and captured request
module mem_responder_channel
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int LATENCY      = 2,
    parameter int WRITE_ENABLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read_valid,
    input  logic [ADDR_BITS-1:0] read_address,
    input  logic                 write_valid,
    input  logic [ADDR_BITS-1:0] write_address,
    input  logic [DATA_BITS-1:0] write_data,
    output logic                 read_ready,
    output logic                 write_ready,
    output logic                 commit,
    output logic                 sample,
    output logic [ADDR_BITS-1:0] addr,
    output logic [DATA_BITS-1:0] data
);
    localparam logic [LAT_CNT_BITS-1:0] LAT = LAT_CNT_BITS'(LATENCY);

    mr_state_t state, state_next;
    mr_op_t op, op_next;
    logic [LAT_CNT_BITS-1:0] cnt, cnt_next;
    logic [ADDR_BITS-1:0] addr_next;
    logic [DATA_BITS-1:0] data_next;
    logic done;

    // The last BUSY cycle is the one whose closing edge enters RESP; commits and samples happen there
    assign done        = (state == MR_BUSY) && (cnt == '0);
    assign commit      = reset && done && (op == MR_WRITE);
    assign sample      = reset && done && (op == MR_READ);
    assign read_ready  = (state == MR_RESP) && (op == MR_READ);
    assign write_ready = (WRITE_ENABLE != 0) && (state == MR_RESP) && (op == MR_WRITE);

    // Next-state: capture in IDLE (read has priority), count down in BUSY, hold RESP until valid drops
    always_comb begin
        state_next = state;
        op_next    = op;
        cnt_next   = cnt;
        addr_next  = addr;
        data_next  = data;
        case (state)
            MR_IDLE: begin
                if (read_valid) begin
                    state_next = MR_BUSY;
                    op_next    = MR_READ;
                    addr_next  = read_address;
                    cnt_next   = LAT;
                end else if ((WRITE_ENABLE != 0) && write_valid) begin
                    state_next = MR_BUSY;
                    op_next    = MR_WRITE;
                    addr_next  = write_address;
                    data_next  = write_data;
                    cnt_next   = LAT;
                end
            end
            MR_BUSY: begin
                if (cnt == '0) state_next = MR_RESP;
                else cnt_next = cnt - 1'b1;
            end
            MR_RESP: begin
                if (!(op == MR_READ ? read_valid : write_valid)) state_next = MR_IDLE;
            end
            default: state_next = MR_IDLE;
        endcase
    end

    // State register; captured address/data need no reset since they are only used after capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= MR_IDLE;
            op    <= MR_READ;
            cnt   <= '0;
        end else begin
            state <= state_next;
            op    <= op_next;
            cnt   <= cnt_next;
        end
        addr <= addr_next;
        data <= data_next;
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: multi-channel memory-side responder over one shared register-array store
module mem_responder
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int CHANNELS     = 4,
    parameter int LATENCY      = 2,
    parameter int WRITE_ENABLE = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [CHANNELS-1:0]                 read_valid,
    input  logic [CHANNELS-1:0][ADDR_BITS-1:0]  read_address,
    output logic [CHANNELS-1:0]                 read_ready,
    output logic [CHANNELS-1:0][DATA_BITS-1:0]  read_data,
    input  logic [CHANNELS-1:0]                 write_valid,
    input  logic [CHANNELS-1:0][ADDR_BITS-1:0]  write_address,
    input  logic [CHANNELS-1:0][DATA_BITS-1:0]  write_data,
    output logic [CHANNELS-1:0]                 write_ready,
    input  logic                                load_en,
    input  logic [ADDR_BITS-1:0]                load_addr,
    input  logic [DATA_BITS-1:0]                load_data
);
    logic [DATA_BITS-1:0] store [2**ADDR_BITS];
    logic [CHANNELS-1:0] commit, sample;
    logic [CHANNELS-1:0][ADDR_BITS-1:0] addr;
    logic [CHANNELS-1:0][DATA_BITS-1:0] data;

    for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
        mem_responder_channel #(
            .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
            .LATENCY(LATENCY), .WRITE_ENABLE(WRITE_ENABLE)
        ) u_ch (
            .clk(clk), .reset(reset),
            .read_valid(read_valid[g]), .read_address(read_address[g]),
            .write_valid(write_valid[g]), .write_address(write_address[g]),
            .write_data(write_data[g]),
            .read_ready(read_ready[g]), .write_ready(write_ready[g]),
            .commit(commit[g]), .sample(sample[g]), .addr(addr[g]), .data(data[g])
        );
    end

    // Store update: later assignments win, so load goes first and channels run high to low index
    always_ff @(posedge clk) begin
        if (load_en) store[load_addr] <= load_data;
        if (WRITE_ENABLE != 0)
            for (int i = CHANNELS - 1; i >= 0; i--)
                if (commit[i]) store[addr[i]] <= data[i];
    end

    // Read data sampled on RESP entry; sees only writes committed at earlier edges
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++)
            if (!reset) read_data[i] <= '0;
            else if (sample[i]) read_data[i] <= store[addr[i]];
    end
endmodule
